// File: rtl/uart_pkg.sv
// Shared UART constants: default geometry and threshold settings for the UART FIFOs.
package uart_pkg;

    localparam int FIFO_DATA_W    = 8;
    localparam int FIFO_ADDR_W    = 11;
    localparam int FIFO_AF_MARGIN = 16;
    localparam int FIFO_AE_LEVEL  = 16;

endpackage

// File: rtl/uart_fifo_ram.sv
// FIFO storage: synchronous write, combinational read, no reset (maps to distributed RAM).
module uart_fifo_ram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_sync_fifo.sv
// Single-clock UART FIFO with registered status flags, sticky error bits and
// selectable standard / first-word-fall-through read behaviour.
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int DATA_W   = FIFO_DATA_W,
    parameter int ADDR_W   = FIFO_ADDR_W,
    parameter int FWFT     = 0,
    parameter int AF_LEVEL = (2**ADDR_W) - FIFO_AF_MARGIN,
    parameter int AE_LEVEL = FIFO_AE_LEVEL
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic [DATA_W-1:0] din,
    input  logic              wr_en,
    input  logic              rd_en,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);

    localparam int DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   AF_C    = (ADDR_W+1)'(AF_LEVEL);
    localparam logic [ADDR_W:0]   AE_C    = (ADDR_W+1)'(AE_LEVEL);
    localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

    generate
        if (DATA_W < 1 || ADDR_W < 1 || ADDR_W > 30 || (FWFT != 0 && FWFT != 1) ||
            AF_LEVEL < 1 || AF_LEVEL > DEPTH || AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_params
            $error("uart_sync_fifo: illegal parameter combination");
        end
    endgenerate

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count_q;
    logic [ADDR_W:0]   count_nxt;
    logic              full_q;
    logic              empty_q;
    logic              af_q;
    logic              ae_q;
    logic              ovf_q;
    logic              udf_q;
    logic              wr_stb;
    logic              rd_stb;
    logic [DATA_W-1:0] ram_rdata;

    assign wr_stb = wr_en & ~full_q;
    assign rd_stb = rd_en & ~empty_q;

    always_comb begin
        count_nxt = count_q;
        if (flush) begin
            count_nxt = '0;
        end else if (wr_stb && !rd_stb) begin
            count_nxt = count_q + CNT_ONE;
        end else if (rd_stb && !wr_stb) begin
            count_nxt = count_q - CNT_ONE;
        end
    end

    // Flags are computed from the next count so they settle on the same edge as count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            af_q    <= 1'b0;
            ae_q    <= 1'b1;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            count_q <= count_nxt;
            full_q  <= (count_nxt == DEPTH_C);
            empty_q <= (count_nxt == '0);
            af_q    <= (count_nxt >= AF_C);
            ae_q    <= (count_nxt <= AE_C);
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                ovf_q  <= 1'b0;
                udf_q  <= 1'b0;
            end else begin
                if (wr_stb) wr_ptr <= wr_ptr + PTR_ONE;
                if (rd_stb) rd_ptr <= rd_ptr + PTR_ONE;
                if (wr_en && full_q) ovf_q <= 1'b1;
                if (rd_en && empty_q) udf_q <= 1'b1;
            end
        end
    end

    uart_fifo_ram #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_ram (
        .clk  (clk),
        .we   (wr_stb & ~flush),
        .waddr(wr_ptr),
        .wdata(din),
        .raddr(rd_ptr),
        .rdata(ram_rdata)
    );

    generate
        if (FWFT == 0) begin : g_std
            logic [DATA_W-1:0] dout_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    dout_q <= '0;
                end else if (rd_stb && !flush) begin
                    dout_q <= ram_rdata;
                end
            end

            assign dout = dout_q;
        end else begin : g_fwft
            // Head word is shown directly; masked while empty so reset reads back as zero.
            assign dout = empty_q ? '0 : ram_rdata;
        end
    endgenerate

    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

endmodule

// File: tb/tb_uart_sync_fifo.sv
// Scoreboard bench for uart_sync_fifo: one standard-mode and one FWFT instance share stimulus
// and are compared against a queue-based model of the FIFO.
module tb_uart_sync_fifo;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;
    localparam int AF     = 12;
    localparam int AE     = 3;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b0;
    logic              flush = 1'b0;
    logic              wr_en = 1'b0;
    logic              rd_en = 1'b0;
    logic [DATA_W-1:0] din   = '0;

    logic [DATA_W-1:0] dout_s, dout_f;
    logic              full_s, empty_s, af_s, ae_s, ovf_s, udf_s;
    logic              full_f, empty_f, af_f, ae_f, ovf_f, udf_f;
    logic [ADDR_W:0]   count_s, count_f;

    int n_compared   = 0;
    int n_mismatched = 0;

    logic [DATA_W-1:0] model_q[$];
    logic [DATA_W-1:0] exp_q[$];
    bit                model_ovf = 1'b0;
    bit                model_udf = 1'b0;

    always #5 clk = ~clk;

    uart_sync_fifo #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .FWFT(0), .AF_LEVEL(AF), .AE_LEVEL(AE)
    ) u_dut_std (
        .clk(clk), .rst_n(rst_n), .flush(flush), .din(din), .wr_en(wr_en), .rd_en(rd_en),
        .dout(dout_s), .full(full_s), .empty(empty_s), .almost_full(af_s),
        .almost_empty(ae_s), .count(count_s), .overflow(ovf_s), .underflow(udf_s)
    );

    uart_sync_fifo #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .FWFT(1), .AF_LEVEL(AF), .AE_LEVEL(AE)
    ) u_dut_fwft (
        .clk(clk), .rst_n(rst_n), .flush(flush), .din(din), .wr_en(wr_en), .rd_en(rd_en),
        .dout(dout_f), .full(full_f), .empty(empty_f), .almost_full(af_f),
        .almost_empty(ae_f), .count(count_f), .overflow(ovf_f), .underflow(udf_f)
    );

    task automatic checkValue(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Status outputs of both instances against the model occupancy and sticky bits.
    task automatic checkOutput();
        int c;
        c = model_q.size();
        checkValue("count",        32'(count_s), c);
        checkValue("full",         32'(full_s),  32'(c == DEPTH));
        checkValue("empty",        32'(empty_s), 32'(c == 0));
        checkValue("almost_full",  32'(af_s),    32'(c >= AF));
        checkValue("almost_empty", 32'(ae_s),    32'(c <= AE));
        checkValue("overflow",     32'(ovf_s),   32'(model_ovf));
        checkValue("underflow",    32'(udf_s),   32'(model_udf));
        checkValue("count_fwft",   32'(count_f), c);
        checkValue("full_fwft",    32'(full_f),  32'(c == DEPTH));
        checkValue("empty_fwft",   32'(empty_f), 32'(c == 0));
        checkValue("af_ae_fwft",   32'({af_f, ae_f}), 32'({c >= AF, c <= AE}));
        checkValue("ovf_udf_fwft", 32'({ovf_f, udf_f}), 32'({model_ovf, model_udf}));
    endtask

    task automatic checkReset(input string tag);
        checkValue({tag, "_count"}, 32'(count_s), 0);
        checkValue({tag, "_flags"}, 32'({full_s, empty_s, af_s, ae_s}), 32'(4'b0101));
        checkValue({tag, "_sticky"}, 32'({ovf_s, udf_s}), 0);
        checkValue({tag, "_dout"}, 32'(dout_s), 0);
        checkValue({tag, "_dout_fwft"}, 32'(dout_f), 0);
        checkValue({tag, "_count_fwft"}, 32'(count_f), 0);
        checkValue({tag, "_flags_fwft"}, 32'({full_f, empty_f, af_f, ae_f, ovf_f, udf_f}), 32'(6'b010100));
    endtask

    // Drive one cycle from a negedge, advance the model at the edge, check at the next negedge.
    task automatic applyStimulus(input bit w, input bit r, input bit f, input logic [DATA_W-1:0] d);
        bit was_full;
        bit was_empty;
        wr_en = w;
        rd_en = r;
        flush = f;
        din   = d;
        @(posedge clk);
        was_full  = (model_q.size() == DEPTH);
        was_empty = (model_q.size() == 0);
        if (f) begin
            model_q.delete();
            model_ovf = 1'b0;
            model_udf = 1'b0;
        end else begin
            if (w && was_full)  model_ovf = 1'b1;
            if (r && was_empty) model_udf = 1'b1;
            if (r && !was_empty) exp_q.push_back(model_q.pop_front());
            if (w && !was_full)  model_q.push_back(d);
        end
        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b0;
        flush = 1'b0;
        checkOutput();
    endtask

    // Read-data monitor: standard instance consumes the scoreboard, FWFT instance tracks the head.
    initial begin
        bit pend;
        forever begin
            @(posedge clk);
            pend = rst_n && rd_en && !empty_s && !flush;
            @(negedge clk);
            if (pend && rst_n) begin
                if (exp_q.size() == 0) begin
                    n_compared++;
                    n_mismatched++;
                    $display("[TB] FAIL dout_std_unexpected: got read data 0x%0h, expected no read accepted", dout_s);
                end else begin
                    checkValue("dout_std", 32'(dout_s), 32'(exp_q.pop_front()));
                end
            end
            if (rst_n && model_q.size() != 0) begin
                checkValue("dout_fwft", 32'(dout_f), 32'(model_q[0]));
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no completion, expected finish before 500000");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        #12;
        checkReset("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Fill to full, then one extra write that must be dropped.
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 1'b0, 1'b0, DATA_W'(i));
        applyStimulus(1'b1, 1'b0, 1'b0, 8'hEE);

        // Drain in order, then one extra read.
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);

        // Wrap-around after a flush.
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 1'b0, 8'($urandom));
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 1'b0, 8'hA0 + 8'(i));
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);

        // Simultaneous accesses at count 5, full and empty.
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'b0, 8'($urandom));
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h55);
        for (int i = 0; i < 11; i++) applyStimulus(1'b1, 1'b0, 1'b0, 8'($urandom));
        applyStimulus(1'b1, 1'b1, 1'b0, 8'hCC);
        for (int i = 0; i < 15; i++) applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h77);

        // Single word into an empty FIFO shows up on the FWFT output without a read.
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h5A);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);

        // Flush at count 9 with a competing write and sticky bits set.
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 9; i++) applyStimulus(1'b1, 1'b0, 1'b0, 8'($urandom));
        applyStimulus(1'b1, 1'b0, 1'b1, 8'h99);

        // Random traffic, write-biased then read-biased so both ends get hit.
        for (int i = 0; i < 400; i++) begin
            bit w, r, f;
            w = ($urandom_range(99) < ((i < 200) ? 75 : 30));
            r = ($urandom_range(99) < ((i < 200) ? 35 : 75));
            f = ($urandom_range(99) < 2);
            applyStimulus(w, r, f, 8'($urandom));
        end

        // Asynchronous reset pulse between clock edges.
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, 1'b0, 8'($urandom));
        #2;
        rst_n = 1'b0;
        #1;
        checkReset("async_reset");
        model_q.delete();
        exp_q.delete();
        model_ovf = 1'b0;
        model_udf = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) applyStimulus(1'($urandom), 1'($urandom), 1'b0, 8'($urandom));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
